// File: rtl/register_file_pkg.sv
// Shared widths and types for the 16x16 register file and its read ports.
// No logic here; 0 latency; no backpressure.
package register_file_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef word_t [DEPTH-1:0] mem_t;

endpackage

// File: rtl/register_file_read_port.sv
// One read port: 16:1 word mux feeding an async-cleared output register.
// 1-cycle latency from address to data_o; loads only when en_i, otherwise holds.
module register_file_read_port
    import register_file_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  mem_t              mem_i,
    output logic [DATA_W-1:0] data_o
);

    word_t data_q;
    word_t data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = mem_i[addr_i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/register_file_16x16.sv
// 16x16 register file, one write port and two registered read ports, mode-multiplexed.
// Write visible next cycle; read latency 1 cycle; no backpressure, every cycle accepted.
module register_file_16x16
    import register_file_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write_read_enable,
    input  logic [ADDR_W-1:0] write_add,
    input  logic [DATA_W-1:0] write_val,
    input  logic [ADDR_W-1:0] read_1_add,
    input  logic [ADDR_W-1:0] read_2_add,
    output logic [DATA_W-1:0] read_1_val,
    output logic [DATA_W-1:0] read_2_val
);

    mem_t  mem_q;
    mem_t  mem_d;
    logic  rd_en;

    // Mode 0 writes, mode 1 reads; the two never share a cycle.
    assign rd_en = write_read_enable;

    always_comb begin
        mem_d = mem_q;
        if (!write_read_enable) begin
            mem_d[write_add] = write_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    register_file_read_port u_rd_port_1 (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (rd_en),
        .addr_i  (read_1_add),
        .mem_i   (mem_q),
        .data_o  (read_1_val)
    );

    register_file_read_port u_rd_port_2 (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (rd_en),
        .addr_i  (read_2_add),
        .mem_i   (mem_q),
        .data_o  (read_2_val)
    );

endmodule

// File: tb/tb_register_file_16x16.sv
// Randomized and directed checks of register_file_16x16 against an array model.
module tb_register_file_16x16;

    logic        clk;
    logic        reset_n;
    logic        write_read_enable;
    logic [3:0]  write_add;
    logic [15:0] write_val;
    logic [3:0]  read_1_add;
    logic [3:0]  read_2_add;
    logic [15:0] read_1_val;
    logic [15:0] read_2_val;

    logic [15:0] ref_mem [16];
    logic [15:0] exp_1;
    logic [15:0] exp_2;

    int n_checks = 0;
    int n_pass   = 0;

    register_file_16x16 dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .write_read_enable (write_read_enable),
        .write_add         (write_add),
        .write_val         (write_val),
        .read_1_add        (read_1_add),
        .read_2_add        (read_2_add),
        .read_1_val        (read_1_val),
        .read_2_val        (read_2_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        exp_1 = 16'h0000;
        exp_2 = 16'h0000;
    endtask

    // Drive one cycle's inputs, clock it, update the model and compare both ports.
    task automatic cycle(input string tag, input logic mode, input logic [3:0] wa,
                         input logic [15:0] wv, input logic [3:0] r1, input logic [3:0] r2);
        write_read_enable = mode;
        write_add         = wa;
        write_val         = wv;
        read_1_add        = r1;
        read_2_add        = r2;
        @(posedge clk);
        if (mode == 1'b0) begin
            ref_mem[wa] = wv;
        end else begin
            exp_1 = ref_mem[r1];
            exp_2 = ref_mem[r2];
        end
        #1;
        chk({tag, ".p1"}, read_1_val, exp_1);
        chk({tag, ".p2"}, read_2_val, exp_2);
    endtask

    initial begin
        reset_n           = 1'b0;
        write_read_enable = 1'b1;
        write_add         = '0;
        write_val         = '0;
        read_1_add        = '0;
        read_2_add        = '0;
        model_reset();
        #3;
        chk("reset.p1", read_1_val, 16'h0000);
        chk("reset.p2", read_2_val, 16'h0000);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        cycle("rd01_after_reset", 1'b1, 4'h0, 16'h0000, 4'h0, 4'h1);

        cycle("wr0", 1'b0, 4'h0, 16'hAAAA, 4'h0, 4'h0);
        cycle("wr1", 1'b0, 4'h1, 16'h5555, 4'h3, 4'h4);
        cycle("wr2", 1'b0, 4'h2, 16'h1234, 4'h5, 4'h6);
        cycle("wrF", 1'b0, 4'hF, 16'hDEAD, 4'h7, 4'h8);
        cycle("rd01", 1'b1, 4'h0, 16'h0000, 4'h0, 4'h1);
        chk("rd01.lit1", read_1_val, 16'hAAAA);
        chk("rd01.lit2", read_2_val, 16'h5555);
        cycle("rd2F", 1'b1, 4'h0, 16'h0000, 4'h2, 4'hF);
        chk("rd2F.lit1", read_1_val, 16'h1234);
        chk("rd2F.lit2", read_2_val, 16'hDEAD);
        cycle("rd11", 1'b1, 4'h0, 16'h0000, 4'h1, 4'h1);
        chk("rd11.lit", read_2_val, 16'h5555);
        cycle("rd37", 1'b1, 4'h0, 16'h0000, 4'h3, 4'h7);
        chk("rd37.lit", read_1_val, 16'h0000);

        // Data staged as a write, but mode flips to read before the edge.
        write_read_enable = 1'b0;
        write_add         = 4'h8;
        write_val         = 16'hBEEF;
        #2;
        cycle("late_mode_switch", 1'b1, 4'h8, 16'hBEEF, 4'h8, 4'h8);
        cycle("rd8_unwritten", 1'b1, 4'h0, 16'h0000, 4'h8, 4'h2);
        chk("rd8.lit", read_1_val, 16'h0000);

        // Outputs must hold through write cycles while read addresses move.
        cycle("hold_a", 1'b0, 4'h2, 16'h1234, 4'h0, 4'hF);
        cycle("hold_b", 1'b0, 4'h5, 16'h7777, 4'h1, 4'h5);
        chk("hold.lit1", read_1_val, 16'h0000);
        chk("hold.lit2", read_2_val, 16'h1234);

        // Asynchronous reset mid-cycle after outputs carry data.
        cycle("pre_arst", 1'b1, 4'h0, 16'h0000, 4'h0, 4'hF);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_now.p1", read_1_val, 16'h0000);
        chk("arst_now.p2", read_2_val, 16'h0000);
        cycle("arst_held_wr", 1'b0, 4'h3, 16'h9999, 4'h3, 4'h3);
        ref_mem[3] = 16'h0000;
        cycle("arst_held_rd", 1'b1, 4'h3, 16'h9999, 4'h3, 4'h3);
        #2;
        reset_n = 1'b1;
        cycle("post_arst_rd3", 1'b1, 4'h0, 16'h0000, 4'h3, 4'h0);

        // Load, pulse reset two cycles, confirm everything cleared.
        for (int i = 0; i < 16; i++) begin
            cycle("load", 1'b0, 4'(i), 16'hC000 | 16'(i), 4'h0, 4'h0);
        end
        cycle("loaded_rd", 1'b1, 4'h0, 16'h0000, 4'h0, 4'hF);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        cycle("pulse_rd01", 1'b1, 4'h0, 16'h0000, 4'h0, 4'h1);
        cycle("pulse_rdF8", 1'b1, 4'h0, 16'h0000, 4'hF, 4'h8);
        chk("pulse.litF", read_1_val, 16'h0000);

        // Fill every address with 0x1000+addr, read (i, i+8) pairs.
        for (int i = 0; i < 16; i++) begin
            cycle("fill", 1'b0, 4'(i), 16'h1000 + 16'(i), 4'h0, 4'h0);
        end
        for (int i = 0; i < 8; i++) begin
            cycle("pair", 1'b1, 4'h0, 16'h0000, 4'(i), 4'(i + 8));
            chk("pair.lit1", read_1_val, 16'h1000 + 16'(i));
            chk("pair.lit2", read_2_val, 16'h1008 + 16'(i));
        end

        // Random mix of writes and reads.
        for (int n = 0; n < 300; n++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
